// File: rtl/dmem_pkg.sv
// Shared definitions for the dcache backing memory and its latency timer.
package dmem_pkg;

  localparam int LINE_W            = 256;
  localparam int OFFSET_BITS       = 5;
  localparam int DEFAULT_LATENCY   = 10;
  localparam int DEFAULT_MEM_LINES = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_latency_timer.sv
// Counts a request's latency; start restarts the count at 1, done pulses one cycle
// after the count reaches LATENCY-1 so the owner moves to ACK exactly LATENCY edges after start.
module dmem_latency_timer #(
  parameter int LATENCY = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic done_o
);

  localparam logic [7:0] LAST = 8'(LATENCY - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       run_q, run_d;
  logic       done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (start_i) begin
      cnt_d = 8'd1;
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q == LAST) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/dcache_backing_memory.sv
// Fixed-latency line memory below the dcache: one 256-bit read/write per request,
// ack_o pulses LATENCY edges after sampling; enable_i is only sampled in IDLE or on the ACK exit edge.
module dcache_backing_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY   = DEFAULT_LATENCY,
  parameter int MEM_LINES = DEFAULT_MEM_LINES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam int IDX_W = $clog2(MEM_LINES);

  generate
    if (LATENCY < 2 || LATENCY > 255) begin : g_bad_latency
      $error("dcache_backing_memory: LATENCY must be within 2..255");
    end
    if ((1 << IDX_W) != MEM_LINES) begin : g_bad_lines
      $error("dcache_backing_memory: MEM_LINES must be a power of two");
    end
  endgenerate

  dmem_state_e       state_q, state_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [LINE_W-1:0] req_data_q, req_data_d;
  logic [IDX_W-1:0]  req_line_q, req_line_d;
  logic              req_write_q, req_write_d;
  logic              accept;
  logic              mem_we;
  logic              timer_done;
  logic [IDX_W-1:0]  addr_line;
  logic              unused_addr_bits;
  logic [LINE_W-1:0] mem_q [MEM_LINES];

  // Upper address bits alias lower lines; byte offset within a line is irrelevant.
  assign addr_line        = addr_i[OFFSET_BITS +: IDX_W];
  assign unused_addr_bits = ^{addr_i[31:OFFSET_BITS+IDX_W], addr_i[OFFSET_BITS-1:0]};

  dmem_latency_timer #(
    .LATENCY(LATENCY)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(accept),
    .done_o (timer_done)
  );

  always_comb begin
    accept      = enable_i && (state_q == IDLE || state_q == ACK);
    state_d     = state_q;
    ack_d       = 1'b0;
    busy_d      = busy_q;
    data_d      = data_q;
    req_data_d  = req_data_q;
    req_line_d  = req_line_q;
    req_write_d = req_write_q;
    mem_we      = 1'b0;

    if (accept) begin
      req_data_d  = data_i;
      req_line_d  = addr_line;
      req_write_d = write_i;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          busy_d  = 1'b1;
        end
      end
      WAIT: begin
        if (timer_done) begin
          state_d = ACK;
          ack_d   = 1'b1;
          if (!req_write_q) data_d = mem_q[req_line_q];
        end
      end
      ACK: begin
        // The write commits on the exit edge, ahead of any read of a follow-on request.
        mem_we  = req_write_q;
        state_d = accept ? WAIT : IDLE;
        busy_d  = accept;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      req_data_q  <= '0;
      req_line_q  <= '0;
      req_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      req_data_q  <= req_data_d;
      req_line_q  <= req_line_d;
      req_write_q <= req_write_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[req_line_q] <= req_data_q;
  end

  assign ack_o  = ack_q;
  assign data_o = data_q;
  assign busy_o = busy_q;

endmodule
